// File: rtl/div_unit_ex_pkg.sv
// div_unit_ex_pkg: shared definitions for the EX-stage iterative divider.
//   div_state_e    : divider FSM state (IDLE/CALC/FIX/DONE)
//   DIV_STEPS      : restoring steps per operation
//   DIV0_QUOTIENT  : quotient returned for a zero divisor
//   div_mag()      : operand magnitude (two's complement abs when signed)
package div_unit_ex_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

  localparam int          DIV_STEPS     = 32;
  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

  // 0x8000_0000 maps onto itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] div_mag(input logic [31:0] x, input logic s);
    return (s && x[31]) ? -x : x;
  endfunction

endpackage

// File: rtl/div_unit_ex_if.sv
// div_unit_ex_if: request/result bundle between EX pipeline control and the
// divider.
//   master (pipeline): drives start/sign/cancel/dividend/divisor,
//                      receives busy/done/quotient/remainder
//   slave  (divider) : the reverse
interface div_unit_ex_if #(parameter int WIDTH = 32);
  logic             start;
  logic             sign;
  logic             cancel;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (output start, sign, cancel, dividend, divisor,
                  input  busy, done, quotient, remainder);
  modport slave  (input  start, sign, cancel, dividend, divisor,
                  output busy, done, quotient, remainder);
endinterface

// File: rtl/div_unit_ex_step.sv
// div_step: one combinational restoring-division step.
//   rem_i/quo_i : current partial remainder / shifting quotient-dividend
//   dvs_i       : divisor magnitude
//   rem_o/quo_o : values after shift, trial subtract and quotient bit insert
module div_step #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);
  logic [WIDTH:0] sh, trial;

  // The shifted remainder needs one extra bit: it can reach 2*dvs-1.
  // trial[WIDTH] is the borrow, i.e. "shifted remainder < divisor".
  assign sh    = {rem_i, quo_i[WIDTH-1]};
  assign trial = sh - {1'b0, dvs_i};
  assign rem_o = trial[WIDTH] ? sh[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_o = {quo_i[WIDTH-2:0], ~trial[WIDTH]};
endmodule

// File: rtl/div_unit_ex.sv
// div_unit_ex: iterative 32-bit DIV/DIVU for the EX stage.
//   clk, rst   : clock, async active-high reset
//   io (slave) : start/sign/cancel/dividend/divisor in,
//                busy (stall request), done (1-cycle pulse),
//                quotient (LO) / remainder (HI) out
// Optional build macro DIV_EARLY_OUT_EN: skip the 32 steps when the divisor
// is zero or |dividend| < |divisor|; results are identical either way.
module div_unit_ex
  import div_unit_ex_pkg::*;
#(parameter int WIDTH = 32) (
  input  logic         clk,
  input  logic         rst,
  div_unit_ex_if.slave io
);
  localparam logic [4:0] LAST_STEP = 5'(DIV_STEPS - 1);

  div_state_e       state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, dvd_q, dvd_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d, div0_q, div0_d;
  logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
  logic [WIDTH-1:0] step_rem, step_quo, mag_a, mag_b;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i(rem_q), .quo_i(quo_q), .dvs_i(dvs_q),
    .rem_o(step_rem), .quo_o(step_quo)
  );

  assign mag_a = div_mag(io.dividend, io.sign);
  assign mag_b = div_mag(io.divisor,  io.sign);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    dvd_d       = dvd_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    div0_d      = div0_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    case (state_q)
      S_IDLE: if (io.start && !io.cancel) begin
        // quo holds the dividend magnitude and shifts out into rem.
        rem_d   = '0;
        quo_d   = mag_a;
        dvs_d   = mag_b;
        dvd_d   = io.dividend;
        cnt_d   = '0;
        qneg_d  = io.sign & (io.dividend[WIDTH-1] ^ io.divisor[WIDTH-1]);
        rneg_d  = io.sign & io.dividend[WIDTH-1];
        div0_d  = (io.divisor == '0);
        state_d = S_CALC;
`ifdef DIV_EARLY_OUT_EN
        // Quotient 0, remainder |dividend|; FIX restores the sign.
        if ((io.divisor == '0) || (mag_a < mag_b)) begin
          rem_d   = mag_a;
          quo_d   = '0;
          state_d = S_FIX;
        end
`endif
      end
      S_CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_STEP) state_d = S_FIX;
      end
      S_FIX: begin
        quotient_d  = qneg_q ? -quo_q : quo_q;
        remainder_d = rneg_q ? -rem_q : rem_q;
        if (div0_q) begin
          quotient_d  = DIV0_QUOTIENT;
          remainder_d = dvd_q;
        end
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A flush wins everywhere, including over the FIX write-back.
    if (io.cancel) begin
      state_d     = S_IDLE;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      dvd_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      div0_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      dvd_q       <= dvd_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      div0_q      <= div0_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  // Combinational so the DIV stalls in the very cycle it reaches EX.
  assign io.busy      = !rst && (((state_q == S_IDLE) && io.start && !io.cancel) ||
                                 (state_q == S_CALC) || (state_q == S_FIX));
  assign io.done      = (state_q == S_DONE);
  assign io.quotient  = quotient_q;
  assign io.remainder = remainder_q;
endmodule

// File: tb/tb_div_unit_ex.sv
module tb_div_unit_ex;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  div_unit_ex_if #(.WIDTH(32)) io();

  div_unit_ex #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .io(io));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int lat(input bit early);
`ifdef DIV_EARLY_OUT_EN
    return early ? 2 : 34;
`else
    return early ? 34 : 34;
`endif
  endfunction

  // Start held until done (frozen pipeline), still high in the DONE cycle.
  task automatic do_div(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eq,
                        input logic [31:0] er, input int exp_lat);
    int cyc, bcnt;
    @(posedge clk); #1;
    io.start = 1'b1; io.sign = s; io.dividend = a; io.divisor = b;
    cyc = 0; bcnt = 0;
    while (cyc < 100) begin
      @(negedge clk);
      if (io.busy) bcnt++;
      if (io.done) break;
      cyc++;
    end
    check({tag, " latency"},   32'(cyc), 32'(exp_lat));
    check({tag, " busy_cyc"},  32'(bcnt), 32'(exp_lat));
    check({tag, " quotient"},  io.quotient, eq);
    check({tag, " remainder"}, io.remainder, er);
    @(posedge clk); #1;
    io.start = 1'b0;
    @(negedge clk);
    check({tag, " post busy"}, 32'(io.busy), 32'd0);
    check({tag, " post done"}, 32'(io.done), 32'd0);
  endtask

  initial begin
    int dcount;
    io.start = 1'b0; io.sign = 1'b0; io.cancel = 1'b0;
    io.dividend = '0; io.divisor = '0;
    #12;
    check("rst busy", 32'(io.busy), 32'd0);
    check("rst done", 32'(io.done), 32'd0);
    check("rst quotient", io.quotient, 32'd0);
    check("rst remainder", io.remainder, 32'd0);
    @(negedge clk); rst = 1'b0;

    do_div("divu 100/7",   1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         lat(0));
    do_div("div -7/2",     1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, lat(0));
    do_div("div 7/-2",     1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         lat(0));
    do_div("div ovf",      1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         lat(0));
    do_div("divu max/1",   1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,         lat(0));
    do_div("div 0x1234/0", 1'b1, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 32'h0000_1234, lat(1));
    do_div("div neg/0",    1'b1, 32'hFFFF_EDCC, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_EDCC, lat(1));
    do_div("divu 3/10",    1'b0, 32'd3,         32'd10,        32'd0,         32'd3,         lat(1));
    do_div("divu max/16",  1'b0, 32'hFFFF_FFFF, 32'd16,        32'h0FFF_FFFF, 32'd15,        lat(0));

    // Cancel at T+10: no done, previous result retained.
    @(posedge clk); #1;
    io.start = 1'b1; io.sign = 1'b0; io.dividend = 32'd1000; io.divisor = 32'd10;
    repeat (10) @(posedge clk);
    #1; io.start = 1'b0; io.cancel = 1'b1;
    @(posedge clk); #1; io.cancel = 1'b0;
    @(negedge clk);
    check("cancel busy", 32'(io.busy), 32'd0);
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (io.done) dcount++;
    end
    check("cancel no done", 32'(dcount), 32'd0);
    check("cancel quotient", io.quotient, 32'h0FFF_FFFF);
    check("cancel remainder", io.remainder, 32'd15);
    do_div("divu after cancel", 1'b0, 32'd1001, 32'd10, 32'd100, 32'd1, lat(0));

    // Asynchronous reset in the middle of an operation.
    @(posedge clk); #1;
    io.start = 1'b1; io.sign = 1'b1; io.dividend = 32'hFFFF_FF9C; io.divisor = 32'd7;
    repeat (20) @(posedge clk);
    #2; rst = 1'b1; #1;
    check("midrst busy", 32'(io.busy), 32'd0);
    check("midrst done", 32'(io.done), 32'd0);
    check("midrst quotient", io.quotient, 32'd0);
    check("midrst remainder", io.remainder, 32'd0);
    io.start = 1'b0;
    @(negedge clk); rst = 1'b0;
    do_div("div -100/7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, lat(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
